// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and default sizing for the BIST sequencer.
package bist_pkg;
    typedef enum logic [2:0] {IDLE, SEED, RUN, CMP, DONE} bist_state_t;
    localparam int BIST_SIG_W      = 4;
    localparam int BIST_CNT_W      = 5;
    localparam int BIST_N_PATTERNS = 31;
endpackage

// File: rtl/bist_pat_counter.sv
// bist_pat_counter: pattern counter with clear/enable; tc flags the last RUN cycle.
module bist_pat_counter
    import bist_pkg::*;
#(
    parameter int CNT_W      = BIST_CNT_W,
    parameter int N_PATTERNS = BIST_N_PATTERNS
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= r_cnt + CNT_W'(1);
    assign tc = r_cnt == CNT_W'(N_PATTERNS - 1);
endmodule

// File: rtl/bist_ctrl.sv
// bist_ctrl: seeds the LFSR/SISR chain, runs it N_PATTERNS cycles and checks the signature.
// Defining BIST_SIG_CAPTURE_EN adds sig_cap, the signature sampled on CMP exit.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int               SIG_W      = BIST_SIG_W,
    parameter int               N_PATTERNS = BIST_N_PATTERNS,
    parameter logic [SIG_W-1:0] GOLDEN     = '0,
    parameter int               CNT_W      = BIST_CNT_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [SIG_W-1:0] sig,
    output logic             tpg_rst_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef BIST_SIG_CAPTURE_EN
    output logic [SIG_W-1:0] sig_cap,
`endif
    output logic             fail
);
    bist_state_t r_state;
    logic        r_tpg_rst_b, r_busy, r_done, r_pass, r_fail;
    logic        w_tc, w_go;

    assign w_go = start && (r_state == IDLE || r_state == DONE);

    bist_pat_counter #(.CNT_W(CNT_W), .N_PATTERNS(N_PATTERNS)) u_cnt (
        .clk  (clk),
        .rst_b(rst_b),
        .clr  (r_state == SEED),
        .en   (r_state == RUN),
        .tc   (w_tc)
    );

    // Outputs are registered alongside the state so the chain reset is glitch-free.
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            r_state     <= IDLE;
            r_tpg_rst_b <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE:
                    if (w_go) begin
                        r_state <= SEED;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                SEED: begin
                    r_state     <= RUN;
                    r_tpg_rst_b <= 1'b1;
                end
                RUN:
                    if (w_tc)
                        r_state <= CMP;
                CMP: begin
                    r_state     <= DONE;
                    r_tpg_rst_b <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_pass      <= sig == GOLDEN;
                    r_fail      <= sig != GOLDEN;
                end
                default:
                    r_state <= IDLE;
            endcase
        end

`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_W-1:0] r_sig_cap;
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b)
            r_sig_cap <= '0;
        else if (w_go)
            r_sig_cap <= '0;
        else if (r_state == CMP)
            r_sig_cap <= sig;
    assign sig_cap = r_sig_cap;
`endif

    assign tpg_rst_b = r_tpg_rst_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
endmodule
